// File: rtl/mem_utils_pkg.sv
// rtl/mem_utils_pkg.sv - shared types and helpers for the core memory bridge
package mem_utils;

    typedef enum logic [1:0] {
        MS_BYTE = 2'b00,
        MS_HALF = 2'b01,
        MS_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_LAUNCH = 3'd0,
        ST_ACC0   = 3'd1,
        ST_ACC1   = 3'd2,
        ST_STEP   = 3'd3,
        ST_ERROR  = 3'd4
    } bridge_state_t;

    // Core size code 11 is an alias for a full word.
    function automatic mem_size_t decode_size(input logic [1:0] code);
        case (code)
            2'b00:   decode_size = MS_BYTE;
            2'b01:   decode_size = MS_HALF;
            default: decode_size = MS_WORD;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input mem_size_t sz);
        case (sz)
            MS_BYTE: size_bytes = 3'd1;
            MS_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - lane mask, write-data positioning and read-data extraction
module byte_lane_align
    import mem_utils::*;
(
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic [31:0] wdata_in,
    input  logic [63:0] rdata_pair,
    output logic [7:0]  lane_mask,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata_out
);

    logic [7:0]  base_mask;
    logic [63:0] rdata_sh;

    // Lanes span two words; the upper nibble of the mask belongs to the second transfer.
    always_comb begin
        base_mask = (8'd1 << size_bytes(size)) - 8'd1;
        lane_mask = base_mask << offset;
        wdata_sh  = {32'b0, wdata_in} << {offset, 3'b000};
        rdata_sh  = rdata_pair >> {offset, 3'b000};
        case (size)
            MS_BYTE: rdata_out = {24'b0, rdata_sh[7:0]};
            MS_HALF: rdata_out = {16'b0, rdata_sh[15:0]};
            default: rdata_out = rdata_sh[31:0];
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - core step to word-memory bridge with split access and watchdog
module mem_bridge
    import mem_utils::*;
#(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [31:0]       core_address,
    input  logic [31:0]       core_data_out,
    input  logic              core_write_enable,
    input  logic [1:0]        core_data_size,
    output logic [31:0]       core_data_in,
    output logic              enable_step,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              bus_error
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    bridge_state_t   state;
    logic [WD_W-1:0] wd_cnt;
    logic [1:0]      off_q;
    mem_size_t       size_q;
    logic            split_q;
    logic [3:0]      be_hi_q;
    logic [31:0]     wdata_hi_q;
    logic [31:0]     r0_q;

    logic [1:0]      al_offset;
    mem_size_t       al_size;
    logic [63:0]     al_rpair;
    logic [7:0]      lane_mask;
    logic [63:0]     wdata_sh;
    logic [31:0]     rdata_out;

    // One aligner serves both launch (live core inputs) and read return (captured access).
    always_comb begin
        al_offset = (state == ST_LAUNCH) ? core_address[1:0] : off_q;
        al_size   = (state == ST_LAUNCH) ? decode_size(core_data_size) : size_q;
        al_rpair  = (state == ST_ACC1) ? {mem_rdata, r0_q} : {32'b0, mem_rdata};
    end

    byte_lane_align u_align (
        .offset     (al_offset),
        .size       (al_size),
        .wdata_in   (core_data_out),
        .rdata_pair (al_rpair),
        .lane_mask  (lane_mask),
        .wdata_sh   (wdata_sh),
        .rdata_out  (rdata_out)
    );

    // Access sequencer: launch, one or two handshaked transfers, step pulse; watchdog traps to ERROR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_LAUNCH;
            wd_cnt       <= '0;
            off_q        <= '0;
            size_q       <= MS_BYTE;
            split_q      <= 1'b0;
            be_hi_q      <= '0;
            wdata_hi_q   <= '0;
            r0_q         <= '0;
            core_data_in <= '0;
            enable_step  <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            bus_error    <= 1'b0;
        end else begin
            case (state)
                ST_LAUNCH: begin
                    enable_step <= 1'b0;
                    if (run) begin
                        off_q      <= core_address[1:0];
                        size_q     <= decode_size(core_data_size);
                        split_q    <= |lane_mask[7:4];
                        be_hi_q    <= lane_mask[7:4];
                        wdata_hi_q <= wdata_sh[63:32];
                        mem_addr   <= core_address[ADDR_W+1:2];
                        mem_be     <= lane_mask[3:0];
                        mem_wdata  <= wdata_sh[31:0];
                        mem_we     <= core_write_enable;
                        mem_req    <= 1'b1;
                        wd_cnt     <= '0;
                        state      <= ST_ACC0;
                    end
                end
                ST_ACC0, ST_ACC1: begin
                    if (mem_ack) begin
                        wd_cnt <= '0;
                        if (state == ST_ACC0 && split_q) begin
                            r0_q      <= mem_rdata;
                            mem_addr  <= mem_addr + 1'b1;
                            mem_be    <= be_hi_q;
                            mem_wdata <= wdata_hi_q;
                            state     <= ST_ACC1;
                        end else begin
                            mem_req     <= 1'b0;
                            enable_step <= 1'b1;
                            if (!mem_we) begin
                                core_data_in <= rdata_out;
                            end
                            state <= ST_STEP;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= ST_ERROR;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_STEP: begin
                    enable_step <= 1'b0;
                    state       <= ST_LAUNCH;
                end
                ST_ERROR: begin
                    mem_req     <= 1'b0;
                    enable_step <= 1'b0;
                    bus_error   <= 1'b1;
                end
                default: state <= ST_LAUNCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - directed scoreboard bench for mem_bridge
module tb_mem_bridge;

    localparam int ADDR_W  = 30;
    localparam int TIMEOUT = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [31:0]       core_address;
    logic [31:0]       core_data_out;
    logic              core_write_enable;
    logic [1:0]        core_data_size;
    logic [31:0]       core_data_in;
    logic              enable_step;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              bus_error;

    mem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .run               (run),
        .core_address      (core_address),
        .core_data_out     (core_data_out),
        .core_write_enable (core_write_enable),
        .core_data_size    (core_data_size),
        .core_data_in      (core_data_in),
        .enable_step       (enable_step),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic              we;
    } xfer_t;

    xfer_t       sb_q[$];
    logic [31:0] step_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_xfer(input logic [ADDR_W-1:0] a, input logic [3:0] be,
                             input logic [31:0] wd, input logic we);
        xfer_t x;
        x.addr = a; x.be = be; x.wdata = wd; x.we = we;
        sb_q.push_back(x);
    endtask

    // Drive one core access starting in LAUNCH; memory acks each transfer after 'waits' cycles.
    task automatic run_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic we, input logic [1:0] sz, input int waits,
                              input logic [31:0] rd0, input logic [31:0] rd1, input int exp_cycle);
        int   cyc;
        int   wcnt;
        int   xfer;
        logic done;
        xfer_t x;
        logic [31:0] exp_d;
        core_address = a; core_data_out = d; core_write_enable = we; core_data_size = sz;
        mem_ack = 1'b0; run = 1'b1;
        cyc = 1; wcnt = 0; xfer = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (enable_step) begin
                run = 1'b0;
                done = 1'b1;
                chk({tag, "_step_cycle"}, 64'(cyc), 64'(exp_cycle));
                if (step_q.size() == 0) chk({tag, "_step_q_empty"}, 64'd1, 64'd0);
                else begin
                    exp_d = step_q.pop_front();
                    chk({tag, "_data_in"}, 64'(core_data_in), 64'(exp_d));
                end
                chk({tag, "_xfers_left"}, 64'(sb_q.size()), 64'd0);
            end else if (mem_req) begin
                if (wcnt == waits) begin
                    mem_ack = 1'b1;
                    mem_rdata = (xfer == 0) ? rd0 : rd1;
                    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
                    else begin
                        x = sb_q.pop_front();
                        chk({tag, "_addr"}, 64'(mem_addr), 64'(x.addr));
                        chk({tag, "_be"}, 64'(mem_be), 64'(x.be));
                        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(x.wdata));
                        chk({tag, "_we"}, 64'(mem_we), 64'(x.we));
                    end
                    xfer++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        if (!done) chk({tag, "_step_timeout"}, 64'd0, 64'd1);
        mem_ack = 1'b0;
        run = 1'b0;
        sb_q.delete();
        step_q.delete();
    endtask

    initial begin
        int seen_req;
        int seen_step;
        rst = 1'b0; run = 1'b0; core_address = '0; core_data_out = '0;
        core_write_enable = 1'b0; core_data_size = 2'b00; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({enable_step, mem_req, mem_we, bus_error}), 64'd0);
        chk("reset_bus", 64'({mem_addr, mem_be}), 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        chk("reset_data_in", 64'(core_data_in), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // run low: bridge must stay idle
        core_address = 32'h100; core_data_size = 2'b10;
        seen_req = 0; seen_step = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) seen_req++;
            if (enable_step) seen_step++;
        end
        chk("run0_req", 64'(seen_req), 64'd0);
        chk("run0_step", 64'(seen_step), 64'd0);

        push_xfer(30'h40, 4'b1111, 32'h0, 1'b0);
        step_q.push_back(32'hDEADBEEF);
        run_access("word_rd", 32'h100, 32'h0, 1'b0, 2'b10, 0, 32'hDEADBEEF, 32'h0, 3);
        @(negedge clk);

        push_xfer(30'h40, 4'b1000, 32'hAB000000, 1'b1);
        step_q.push_back(32'hDEADBEEF);
        run_access("byte_wr", 32'h103, 32'h000000AB, 1'b1, 2'b00, 0, 32'h0, 32'h0, 3);
        @(negedge clk);

        push_xfer(30'h80, 4'b1000, 32'h0, 1'b0);
        push_xfer(30'h81, 4'b0001, 32'h0, 1'b0);
        step_q.push_back(32'h00008811);
        run_access("split_half_rd", 32'h203, 32'h0, 1'b0, 2'b01, 0, 32'h11223344, 32'h55667788, 4);
        @(negedge clk);

        push_xfer(30'h0, 4'b1110, 32'hFEBABE00, 1'b1);
        push_xfer(30'h1, 4'b0001, 32'h000000CA, 1'b1);
        step_q.push_back(32'h00008811);
        run_access("split_word_wr", 32'h001, 32'hCAFEBABE, 1'b1, 2'b10, 0, 32'h0, 32'h0, 4);
        @(negedge clk);

        push_xfer(30'h1, 4'b1100, 32'h0, 1'b0);
        step_q.push_back(32'h0000A1B2);
        run_access("half_hi_rd", 32'h006, 32'h0, 1'b0, 2'b01, 0, 32'hA1B2C3D4, 32'h0, 3);
        @(negedge clk);

        push_xfer(30'h2, 4'b1111, 32'h0, 1'b0);
        step_q.push_back(32'h0BADF00D);
        run_access("size11_rd", 32'h008, 32'h0, 1'b0, 2'b11, 0, 32'h0BADF00D, 32'h0, 3);
        @(negedge clk);

        push_xfer(30'h3FFFFFFF, 4'b1000, 32'h0, 1'b0);
        push_xfer(30'h0, 4'b0001, 32'h0, 1'b0);
        step_q.push_back(32'h0000F012);
        run_access("wrap_rd", 32'hFFFFFFFF, 32'h0, 1'b0, 2'b01, 0, 32'h12345678, 32'h9ABCDEF0, 4);
        @(negedge clk);

        push_xfer(30'h4, 4'b1111, 32'h0, 1'b0);
        step_q.push_back(32'h5A5A1234);
        run_access("wait5_rd", 32'h010, 32'h0, 1'b0, 2'b10, 5, 32'h5A5A1234, 32'h0, 8);
        @(negedge clk);

        // watchdog: no ack ever
        core_address = 32'h020; core_data_out = '0; core_write_enable = 1'b0; core_data_size = 2'b10;
        mem_ack = 1'b0; run = 1'b1;
        repeat (TIMEOUT) @(negedge clk);
        chk("wd_before_err", 64'(bus_error), 64'd0);
        chk("wd_before_req", 64'(mem_req), 64'd1);
        @(negedge clk);
        chk("wd_err", 64'(bus_error), 64'd1);
        chk("wd_err_req", 64'(mem_req), 64'd0);
        seen_req = 0; seen_step = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) seen_req++;
            if (enable_step) seen_step++;
        end
        chk("err_no_req", 64'(seen_req), 64'd0);
        chk("err_no_step", 64'(seen_step), 64'd0);
        chk("err_sticky", 64'(bus_error), 64'd1);
        run = 1'b0;
        rst = 1'b0;
        #1;
        chk("err_cleared", 64'(bus_error), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset asserted while the second transfer of a split access is outstanding
        core_address = 32'h203; core_data_size = 2'b01; core_write_enable = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("rst_acc0_addr", 64'(mem_addr), 64'h80);
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_ack = 1'b0; run = 1'b0;
        chk("rst_acc1_req", 64'(mem_req), 64'd1);
        chk("rst_acc1_addr", 64'(mem_addr), 64'h81);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({enable_step, mem_req, mem_we, bus_error, mem_be}), 64'd0);
        chk("rst_mid_addr", 64'(mem_addr), 64'd0);
        chk("rst_mid_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mid_data_in", 64'(core_data_in), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        push_xfer(30'h40, 4'b1111, 32'h0, 1'b0);
        step_q.push_back(32'h76543210);
        run_access("after_rst_rd", 32'h100, 32'h0, 1'b0, 2'b10, 0, 32'h76543210, 32'h0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
